bitnn_mem_arb: RTL

//  Arbiter and tag router between bitNN's memory clients and the single unified mem port.

---
 rtl/bitnn_mem_arb_if.sv | 37 +++
 rtl/bitnn_mem_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bitnn_mem_arb_if.sv
// rtl/bitnn_mem_arb_if.sv - client request/response and unified mem port bundle for bitnn_mem_arb
// master = arbiter side, slave = clients plus memory.
interface bitnn_mem_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 4
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][1:0]        req_cmd;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;

  logic [1:0]        proc2mem_command;
  logic [ADDR_W-1:0] proc2mem_addr;
  logic [DATA_W-1:0] proc2mem_data;
  logic [TAG_W-1:0]  mem2proc_transaction_tag;
  logic [DATA_W-1:0] mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_data_tag;

  modport master (
    input  req_valid, req_cmd, req_addr, req_data,
    input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
    output req_ready, rsp_valid, rsp_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data
  );

  modport slave (
    output req_valid, req_cmd, req_addr, req_data,
    output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
    input  req_ready, rsp_valid, rsp_data,
    input  proc2mem_command, proc2mem_addr, proc2mem_data
  );
endinterface

// File: rtl/bitnn_mem_arb.sv
// rtl/bitnn_mem_arb.sv - arbiter and tag router between bitNN memory clients and the unified mem port
// MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins); default is round-robin.
module bitnn_mem_arb #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_OUTST = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 4
) (
  input  logic clock,
  input  logic reset,
  bitnn_mem_arb_if.master bus,
  output logic idle,
  output logic tag_err
);
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_TAGS = 1 << TAG_W;

  // Command encoding: 0 = none, 1 = load, 2 = store
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e                        state_q, state_d;
  logic [1:0]                    iss_cmd_q, iss_cmd_d;
  logic [ADDR_W-1:0]             iss_addr_q, iss_addr_d;
  logic [DATA_W-1:0]             iss_data_q, iss_data_d;
  logic [ID_W-1:0]               iss_id_q, iss_id_d;
  logic [NUM_TAGS-1:0]           tag_vld_q, tag_vld_d;
  logic [NUM_TAGS-1:0][ID_W-1:0] tag_own_q, tag_own_d;
  logic [3:0]                    outst_q, outst_d;
  logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]             rsp_data_q, rsp_data_d;
  logic                          tag_err_q, tag_err_d;
  logic                          idle_q, idle_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
`endif

  logic               accept, arb_en, load_ok, win;
  logic [ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0] elig, req_ready_d;
  logic [4:0]         committed;
  logic               inc, dec;

  assign accept = (state_q == S_ISSUE) && (bus.mem2proc_transaction_tag != '0);
  assign arb_en = (state_q == S_IDLE) || accept;

  // A load sitting in the issue register is about to occupy a tag, so it counts against the cap.
  assign committed = {1'b0, outst_q} + 5'((state_q == S_ISSUE) && (iss_cmd_q == MEM_LOAD));
  assign load_ok   = committed < 5'(MAX_OUTST);

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_valid[i] && (bus.req_cmd[i] != MEM_NONE) &&
                ((bus.req_cmd[i] != MEM_LOAD) || load_ok);
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    win    = 1'b0;
    win_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig[k]) begin
        win    = 1'b1;
        win_id = ID_W'(k);
      end
    end
  end
`else
  always_comb begin
    int idx;
    idx    = 0;
    win    = 1'b0;
    win_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win && elig[idx]) begin
        win    = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    iss_cmd_d   = iss_cmd_q;
    iss_addr_d  = iss_addr_q;
    iss_data_d  = iss_data_q;
    iss_id_d    = iss_id_q;
    tag_vld_d   = tag_vld_q;
    tag_own_d   = tag_own_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    tag_err_d   = tag_err_q;
    req_ready_d = '0;
    inc         = 1'b0;
    dec         = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    if (arb_en && win) begin
      state_d             = S_ISSUE;
      iss_cmd_d           = bus.req_cmd[win_id];
      iss_addr_d          = bus.req_addr[win_id];
      iss_data_d          = bus.req_data[win_id];
      iss_id_d            = win_id;
      req_ready_d[win_id] = 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
`endif
    end else if (accept) begin
      state_d = S_IDLE;
    end

    if (bus.mem2proc_data_tag != '0) begin
      if (tag_vld_q[bus.mem2proc_data_tag]) begin
        rsp_valid_d[tag_own_q[bus.mem2proc_data_tag]] = 1'b1;
        rsp_data_d                                    = bus.mem2proc_data;
        tag_vld_d[bus.mem2proc_data_tag]              = 1'b0;
        dec                                           = 1'b1;
      end else begin
        tag_err_d = 1'b1;
      end
    end

    // Applied after the response clear so a reused tag ends up owned by the new load.
    if (accept && (iss_cmd_q == MEM_LOAD)) begin
      tag_vld_d[bus.mem2proc_transaction_tag] = 1'b1;
      tag_own_d[bus.mem2proc_transaction_tag] = iss_id_q;
      inc                                     = 1'b1;
    end

    outst_d = outst_q + 4'(inc) - 4'(dec);
    idle_d  = (state_d == S_IDLE) && (outst_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      iss_cmd_q   <= MEM_NONE;
      iss_addr_q  <= '0;
      iss_data_q  <= '0;
      iss_id_q    <= '0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      outst_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      tag_err_q   <= 1'b0;
      idle_q      <= 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      iss_cmd_q   <= iss_cmd_d;
      iss_addr_q  <= iss_addr_d;
      iss_data_q  <= iss_data_d;
      iss_id_q    <= iss_id_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
      outst_q     <= outst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tag_err_q   <= tag_err_d;
      idle_q      <= idle_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign bus.req_ready        = req_ready_d;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.proc2mem_command = (state_q == S_ISSUE) ? iss_cmd_q : MEM_NONE;
  assign bus.proc2mem_addr    = (state_q == S_ISSUE) ? iss_addr_q : '0;
  assign bus.proc2mem_data    = (state_q == S_ISSUE) ? iss_data_q : '0;
  assign idle                 = idle_q;
  assign tag_err              = tag_err_q;
endmodule
